// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts exceptions, timer interrupts and mret at the commit
// boundary, owns the M-mode trap CSRs and redirects the PC to mtvec or mepc.
module trap_ctrl #(
  parameter logic [31:0] MTVEC_RESET     = 32'h0000_0100,
  parameter logic [31:0] IRQ_TIMER_CAUSE = 32'h8000_0007
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_pc_i,
  input  logic        exc_request_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] trap_info_i,
  input  logic        exc_ret_i,
  input  logic        timer_irq_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [2:0]  pc_sel_o,
  output logic [31:0] trap_pc_o
);

  typedef enum logic [2:0] {StIdle, StSave, StCause, StRedirect, StRet} state_e;

  localparam logic [2:0] PcPlus4 = 3'b000;
  localparam logic [2:0] PcMtvec = 3'b011;
  localparam logic [2:0] PcMepc  = 3'b100;

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMie     = 12'h304;
  localparam logic [11:0] AddrMtvec   = 12'h305;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;
  localparam logic [11:0] AddrMtval   = 12'h343;
  localparam logic [11:0] AddrMip     = 12'h344;

  localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

  state_e      state_q;
  logic        mstatus_mie_q, mstatus_mpie_q, mie_mtie_q;
  logic [31:0] mtvec_q, mepc_q, mcause_q, mtval_q;
  logic [31:0] cause_q, tval_q, epc_q;

  logic irq_pend, accept_trap, accept_ret;

  always_comb begin
    irq_pend    = timer_irq_i & mstatus_mie_q & mie_mtie_q;
    accept_trap = (state_q == StIdle) & instr_valid_i & (irq_pend | exc_request_i);
    accept_ret  = (state_q == StIdle) & instr_valid_i & ~irq_pend & ~exc_request_i & exc_ret_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RESET & AlignMask;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      cause_q        <= '0;
      tval_q         <= '0;
      epc_q          <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept_trap) begin
            cause_q <= irq_pend ? IRQ_TIMER_CAUSE : exc_cause_i;
            tval_q  <= irq_pend ? 32'h0 : trap_info_i;
            epc_q   <= instr_pc_i & AlignMask;
            state_q <= StSave;
          end else if (accept_ret) begin
            state_q <= StRet;
          end else if (csr_we_i) begin
            case (csr_addr_i)
              AddrMstatus: begin
                mstatus_mie_q  <= csr_wdata_i[3];
                mstatus_mpie_q <= csr_wdata_i[7];
              end
              AddrMie:    mie_mtie_q <= csr_wdata_i[7];
              AddrMtvec:  mtvec_q    <= csr_wdata_i & AlignMask;
              AddrMepc:   mepc_q     <= csr_wdata_i & AlignMask;
              AddrMcause: mcause_q   <= csr_wdata_i;
              AddrMtval:  mtval_q    <= csr_wdata_i;
              default: ;
            endcase
          end
        end
        StSave: begin
          mepc_q  <= epc_q;
          mtval_q <= tval_q;
          state_q <= StCause;
        end
        StCause: begin
          mcause_q       <= cause_q;
          mstatus_mpie_q <= mstatus_mie_q;
          mstatus_mie_q  <= 1'b0;
          state_q        <= StRedirect;
        end
        StRedirect: state_q <= StIdle;
        StRet: begin
          mstatus_mie_q  <= mstatus_mpie_q;
          mstatus_mpie_q <= 1'b1;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode from the registered state; only the accept-cycle stall is combinational.
  always_comb begin
    stall_o   = 1'b0;
    flush_o   = 1'b0;
    pc_sel_o  = PcPlus4;
    trap_pc_o = '0;
    unique case (state_q)
      StIdle:          stall_o = accept_trap | accept_ret;
      StSave, StCause: stall_o = 1'b1;
      StRedirect: begin
        flush_o   = 1'b1;
        pc_sel_o  = PcMtvec;
        trap_pc_o = mtvec_q;
      end
      StRet: begin
        flush_o   = 1'b1;
        pc_sel_o  = PcMepc;
        trap_pc_o = mepc_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      AddrMstatus: csr_rdata_o = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
      AddrMie:     csr_rdata_o = {24'h0, mie_mtie_q, 7'h00};
      AddrMtvec:   csr_rdata_o = mtvec_q;
      AddrMepc:    csr_rdata_o = mepc_q;
      AddrMcause:  csr_rdata_o = mcause_q;
      AddrMtval:   csr_rdata_o = mtval_q;
      AddrMip:     csr_rdata_o = {24'h0, timer_irq_i, 7'h00};
      default:     csr_rdata_o = '0;
    endcase
  end

endmodule
